// File: rtl/fabric_cfg_pkg.sv
// Shared types and constants for the fabric configuration sequencer.
// Holds the FSM state encoding and the serial CRC-8 step used when CFG_CRC_EN is defined.
package fabric_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RST_HOLD = 3'd1,
        FETCH    = 3'd2,
        SHIFT    = 3'd3,
        CRC_CHK  = 3'd4,
        SETTLE   = 3'd5,
        RELEASE  = 3'd6
    } cfg_state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // MSB-first serial CRC: one chain bit per call, in shift order.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/fabric_cfg_crc8.sv
// Serial CRC-8 over the configuration bits as they leave the shift register.
// Only compiled when CFG_CRC_EN is defined; the default build has no CRC logic.
`ifdef CFG_CRC_EN
module fabric_cfg_crc8
    import fabric_cfg_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear_i,
    input  logic       bit_en_i,
    input  logic       bit_i,
    output logic [7:0] crc_o
);

    logic [7:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear_i) begin
            crc_d = 8'h00;
        end else if (bit_en_i) begin
            crc_d = crc8_step(crc_q, bit_i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule
`endif

// File: rtl/fabric_cfg_sequencer.sv
// Loads the fabric configuration chain from a valid/ready byte stream and sequences the FF globals.
// Optional feature macro CFG_CRC_EN: CRC-8 check of the shifted bits against one trailing word.
module fabric_cfg_sequencer
    import fabric_cfg_pkg::*;
#(
    parameter int CHAIN_LEN  = 1024,
    parameter int DATA_W     = 8,
    parameter int RST_CYCLES = 16,
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              prog_clk_en,
    output logic              fabric_reset,
    output logic              fabric_clk_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int RW = $clog2(CHAIN_LEN + 1);
    localparam int KW = $clog2(DATA_W + 1);
    localparam int CW = $clog2(RST_CYCLES + SETTLE_CYC + 1);

    cfg_state_e        state_q, state_d;
    logic [RW-1:0]     remaining_q, remaining_d;
    logic [KW-1:0]     k_q, k_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              fabric_reset_q, fabric_reset_d;
    logic              fabric_clk_en_q, fabric_clk_en_d;
    logic              done_q, done_d;
    logic              accept_start;
`ifdef CFG_CRC_EN
    logic              error_q, error_d;
    logic [7:0]        crc_val;
`endif

    assign accept_start = (state_q == IDLE) && start;

    // k counts bits left in the current word, remaining counts bits left in the chain;
    // a word never loads more bits than the chain still needs, so neither can underflow.
    always_comb begin
        state_d         = state_q;
        remaining_d     = remaining_q;
        k_d             = k_q;
        cnt_d           = cnt_q;
        shreg_d         = shreg_q;
        fabric_reset_d  = fabric_reset_q;
        fabric_clk_en_d = fabric_clk_en_q;
        done_d          = done_q;
`ifdef CFG_CRC_EN
        error_d         = error_q;
`endif
        case (state_q)
            IDLE: begin
                remaining_d = RW'(CHAIN_LEN);
                if (start) begin
                    state_d         = RST_HOLD;
                    cnt_d           = '0;
                    done_d          = 1'b0;
                    fabric_reset_d  = 1'b1;
                    fabric_clk_en_d = 1'b0;
`ifdef CFG_CRC_EN
                    error_d         = 1'b0;
`endif
                end
            end
            RST_HOLD: begin
                if (cnt_q == CW'(RST_CYCLES - 1)) begin
                    state_d = FETCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FETCH: begin
                if (bs_valid) begin
                    shreg_d = bs_data;
                    k_d     = (remaining_q < RW'(DATA_W)) ? KW'(remaining_q) : KW'(DATA_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d     = shreg_q >> 1;
                k_d         = k_q - KW'(1);
                remaining_d = remaining_q - RW'(1);
                if (k_q == KW'(1)) begin
                    if (remaining_q == RW'(1)) begin
`ifdef CFG_CRC_EN
                        state_d = CRC_CHK;
`else
                        state_d = SETTLE;
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
`ifdef CFG_CRC_EN
            CRC_CHK: begin
                if (bs_valid) begin
                    if (bs_data[7:0] == crc_val) begin
                        state_d = SETTLE;
                        cnt_d   = '0;
                    end else begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
`endif
            SETTLE: begin
                if (cnt_q == CW'(SETTLE_CYC - 1)) begin
                    state_d        = RELEASE;
                    fabric_reset_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RELEASE: begin
                fabric_clk_en_d = 1'b1;
                done_d          = 1'b1;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            remaining_q     <= RW'(CHAIN_LEN);
            k_q             <= '0;
            cnt_q           <= '0;
            shreg_q         <= '0;
            fabric_reset_q  <= 1'b1;
            fabric_clk_en_q <= 1'b0;
            done_q          <= 1'b0;
`ifdef CFG_CRC_EN
            error_q         <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            remaining_q     <= remaining_d;
            k_q             <= k_d;
            cnt_q           <= cnt_d;
            shreg_q         <= shreg_d;
            fabric_reset_q  <= fabric_reset_d;
            fabric_clk_en_q <= fabric_clk_en_d;
            done_q          <= done_d;
`ifdef CFG_CRC_EN
            error_q         <= error_d;
`endif
        end
    end

`ifdef CFG_CRC_EN
    fabric_cfg_crc8 u_crc8 (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (accept_start),
        .bit_en_i (prog_clk_en),
        .bit_i    (shreg_q[0]),
        .crc_o    (crc_val)
    );

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign bs_ready      = (state_q == FETCH) || (state_q == CRC_CHK);
    assign prog_clk_en   = (state_q == SHIFT);
    assign ccff_head     = prog_clk_en & shreg_q[0];
    assign fabric_reset  = fabric_reset_q;
    assign fabric_clk_en = fabric_clk_en_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;

endmodule

// File: tb/tb_fabric_cfg_sequencer.sv
// Scoreboard bench for fabric_cfg_sequencer with a 20-bit chain and byte-wide bitstream.
// Build with CFG_CRC_EN defined to append and check the trailing CRC word.
module tb_fabric_cfg_sequencer;

    localparam int CHAIN  = 20;
    localparam int DW     = 8;
    localparam int RSTC   = 4;
    localparam int SETTLE = 2;
`ifdef CFG_CRC_EN
    localparam int EXP_POST = SETTLE + 1;
`else
    localparam int EXP_POST = SETTLE;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [DW-1:0] bs_data;
    logic          bs_valid;
    logic          bs_ready;
    logic          ccff_head;
    logic          prog_clk_en;
    logic          fabric_reset;
    logic          fabric_clk_en;
    logic          busy;
    logic          done;
    logic          error;

    int checks   = 0;
    int failures = 0;

    logic expQ[$];
    logic expBit;
    logic [7:0] words [3];

    bit monitorOn = 1'b0;
    bit seenFirst;
    int pulseCnt;
    int preCnt;
    int preRstBad;
    int postCnt;
    int gapPulses;
    bit drvTimeout;
    bit doneTimeout;

    fabric_cfg_sequencer #(
        .CHAIN_LEN  (CHAIN),
        .DATA_W     (DW),
        .RST_CYCLES (RSTC),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .bs_data       (bs_data),
        .bs_valid      (bs_valid),
        .bs_ready      (bs_ready),
        .ccff_head     (ccff_head),
        .prog_clk_en   (prog_clk_en),
        .fabric_reset  (fabric_reset),
        .fabric_clk_en (fabric_clk_en),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    always #5 clk = ~clk;

    // Pops one expected chain bit per prog_clk_en pulse and tracks reset timing around the shifts.
    always @(negedge clk) begin
        if (monitorOn && reset_n === 1'b1) begin
            if (prog_clk_en === 1'b1) begin
                pulseCnt++;
                seenFirst = 1'b1;
                postCnt   = 0;
                checks++;
                if (expQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL extra_pulse ccff_head=%b required=no pulse", ccff_head);
                end else begin
                    expBit = expQ.pop_front();
                    if (ccff_head !== expBit) begin
                        failures++;
                        $display("[TB] FAIL ccff_bit pulse=%0d got=%b required=%b", pulseCnt, ccff_head, expBit);
                    end
                end
            end else if (busy === 1'b1) begin
                if (!seenFirst) begin
                    preCnt++;
                    if (fabric_reset !== 1'b1) preRstBad++;
                end else if (fabric_reset === 1'b1) begin
                    postCnt++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [7:0] crcModel(input logic [7:0] crc, input logic b);
        logic fb;
        fb = crc[7] ^ b;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    task automatic clearMon();
        seenFirst = 1'b0;
        pulseCnt  = 0;
        preCnt    = 0;
        preRstBad = 0;
        postCnt   = 0;
        expQ.delete();
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitAccept();
        int guard;
        guard = 0;
        while (bs_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) drvTimeout = 1'b1;
        @(negedge clk);
    endtask

    // Drives the three chain words (plus the CRC word when enabled), pushing expected bits as each word is offered.
    task automatic applyStimulus(input int gap, input bit crcFlip);
        int rem;
        int n;
        int guard;
        logic [7:0] crcM;
        rem        = CHAIN;
        crcM       = 8'h00;
        gapPulses  = 0;
        drvTimeout = 1'b0;
        for (int w = 0; w < 3; w++) begin
            if (w > 0 && gap > 0) begin
                bs_valid = 1'b0;
                guard    = 0;
                while (bs_ready !== 1'b1 && guard < 100) begin
                    @(negedge clk);
                    guard++;
                end
                if (guard >= 100) drvTimeout = 1'b1;
                repeat (gap) begin
                    @(negedge clk);
                    if (prog_clk_en === 1'b1) gapPulses++;
                end
            end
            n = (rem < DW) ? rem : DW;
            for (int b = 0; b < n; b++) begin
                expQ.push_back(words[w][b]);
                crcM = crcModel(crcM, words[w][b]);
            end
            rem -= n;
            bs_data  = words[w];
            bs_valid = 1'b1;
            waitAccept();
        end
`ifdef CFG_CRC_EN
        bs_data  = crcM ^ {7'd0, crcFlip};
        bs_valid = 1'b1;
        waitAccept();
`else
        if (crcFlip) drvTimeout = 1'b0;
`endif
        bs_valid = 1'b0;
        bs_data  = '0;
    endtask

    task automatic waitDone();
        int guard;
        guard       = 0;
        doneTimeout = 1'b0;
        while (done !== 1'b1 && error !== 1'b1 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 400) doneTimeout = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (fabric_reset !== 1'b1) begin failures++; $display("[TB] FAIL rst_fabric_reset got=%b required=1", fabric_reset); end
        checks++; if (prog_clk_en !== 1'b0) begin failures++; $display("[TB] FAIL rst_prog_clk_en got=%b required=0", prog_clk_en); end
        checks++; if (fabric_clk_en !== 1'b0) begin failures++; $display("[TB] FAIL rst_fabric_clk_en got=%b required=0", fabric_clk_en); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy got=%b required=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL rst_done got=%b required=0", done); end
        checks++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL rst_error got=%b required=0", error); end
        checks++; if (bs_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_bs_ready got=%b required=0", bs_ready); end
        checks++; if (ccff_head !== 1'b0) begin failures++; $display("[TB] FAIL rst_ccff_head got=%b required=0", ccff_head); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (fabric_reset !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_after_reset fabric_reset=%b busy=%b required=1,0", fabric_reset, busy); end
    endtask

    task automatic test_basic_pass(input int gap);
        clearMon();
        monitorOn = 1'b1;
        pulseStart();
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL start_busy gap=%0d got=%b required=1", gap, busy); end
        applyStimulus(gap, 1'b0);
        waitDone();
        @(negedge clk);
        checks++; if (doneTimeout || drvTimeout) begin failures++; $display("[TB] FAIL pass_timeout gap=%0d done_to=%b drv_to=%b required=0,0", gap, doneTimeout, drvTimeout); end
        checks++; if (pulseCnt !== CHAIN) begin failures++; $display("[TB] FAIL pulse_count gap=%0d got=%0d required=%0d", gap, pulseCnt, CHAIN); end
        checks++; if (expQ.size() != 0) begin failures++; $display("[TB] FAIL bits_left gap=%0d got=%0d required=0", gap, expQ.size()); end
        checks++; if (done !== 1'b1 || fabric_clk_en !== 1'b1) begin failures++; $display("[TB] FAIL release gap=%0d done=%b clk_en=%b required=1,1", gap, done, fabric_clk_en); end
        checks++; if (fabric_reset !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin failures++; $display("[TB] FAIL final_state gap=%0d reset=%b busy=%b error=%b required=0,0,0", gap, fabric_reset, busy, error); end
        checks++; if (preCnt !== RSTC + 1 || preRstBad !== 0) begin failures++; $display("[TB] FAIL pre_shift_reset gap=%0d cycles=%0d bad=%0d required=%0d,0", gap, preCnt, preRstBad, RSTC + 1); end
        checks++; if (postCnt !== EXP_POST) begin failures++; $display("[TB] FAIL post_shift_reset gap=%0d got=%0d required=%0d", gap, postCnt, EXP_POST); end
        if (gap > 0) begin
            checks++; if (gapPulses !== 0) begin failures++; $display("[TB] FAIL gap_pulses got=%0d required=0", gapPulses); end
        end
    endtask

    task automatic test_restart_and_ignored_start();
        clearMon();
        monitorOn = 1'b1;
        pulseStart();
        checks++; if (fabric_clk_en !== 1'b0 || fabric_reset !== 1'b1) begin failures++; $display("[TB] FAIL restart_globals clk_en=%b reset=%b required=0,1", fabric_clk_en, fabric_reset); end
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL restart_flags done=%b busy=%b required=0,1", done, busy); end
        fork
            applyStimulus(0, 1'b0);
            begin
                int guard;
                guard = 0;
                while (prog_clk_en !== 1'b1 && guard < 100) begin
                    @(negedge clk);
                    guard++;
                end
                repeat (3) @(negedge clk);
                pulseStart();
            end
        join
        waitDone();
        @(negedge clk);
        checks++; if (doneTimeout || drvTimeout) begin failures++; $display("[TB] FAIL restart_timeout done_to=%b drv_to=%b required=0,0", doneTimeout, drvTimeout); end
        checks++; if (pulseCnt !== CHAIN || expQ.size() != 0) begin failures++; $display("[TB] FAIL restart_pulses got=%0d left=%0d required=%0d,0", pulseCnt, expQ.size(), CHAIN); end
        checks++; if (done !== 1'b1 || fabric_clk_en !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL restart_release done=%b clk_en=%b busy=%b required=1,1,0", done, fabric_clk_en, busy); end
    endtask

    task automatic test_reset_mid_shift();
        int guard;
        monitorOn = 1'b0;
        pulseStart();
        bs_data  = words[0];
        bs_valid = 1'b1;
        guard    = 0;
        while (prog_clk_en !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        checks++; if (prog_clk_en !== 1'b1) begin failures++; $display("[TB] FAIL mid_shift_reached prog_clk_en=%b required=1", prog_clk_en); end
        reset_n = 1'b0;
        #1;
        checks++; if (fabric_reset !== 1'b1 || prog_clk_en !== 1'b0) begin failures++; $display("[TB] FAIL abort_globals reset=%b prog_clk_en=%b required=1,0", fabric_reset, prog_clk_en); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || fabric_clk_en !== 1'b0) begin failures++; $display("[TB] FAIL abort_flags busy=%b done=%b clk_en=%b required=0,0,0", busy, done, fabric_clk_en); end
        @(negedge clk);
        reset_n  = 1'b1;
        bs_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b0 || fabric_reset !== 1'b1 || prog_clk_en !== 1'b0) begin failures++; $display("[TB] FAIL after_abort done=%b reset=%b prog_clk_en=%b required=0,1,0", done, fabric_reset, prog_clk_en); end
    endtask

`ifdef CFG_CRC_EN
    task automatic test_crc_mismatch();
        clearMon();
        monitorOn = 1'b1;
        pulseStart();
        applyStimulus(0, 1'b1);
        waitDone();
        @(negedge clk);
        checks++; if (doneTimeout || drvTimeout) begin failures++; $display("[TB] FAIL crc_timeout done_to=%b drv_to=%b required=0,0", doneTimeout, drvTimeout); end
        checks++; if (error !== 1'b1 || done !== 1'b0) begin failures++; $display("[TB] FAIL crc_flags error=%b done=%b required=1,0", error, done); end
        checks++; if (fabric_reset !== 1'b1 || fabric_clk_en !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL crc_globals reset=%b clk_en=%b busy=%b required=1,0,0", fabric_reset, fabric_clk_en, busy); end
    endtask
`endif

    initial begin
        words[0] = 8'hA5;
        words[1] = 8'h3C;
        words[2] = 8'hF9;
        start    = 1'b0;
        bs_valid = 1'b0;
        bs_data  = '0;
        reset_n  = 1'b0;
        @(negedge clk);
        $display("[TB] starting fabric_cfg_sequencer bench");
        test_reset();
        test_basic_pass(0);
        test_basic_pass(5);
        test_restart_and_ignored_start();
        test_reset_mid_shift();
        test_basic_pass(0);
`ifdef CFG_CRC_EN
        test_crc_mismatch();
`endif
        monitorOn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
